sync_jk_down_counter: RTL and testbench
=======================================

Name: sync_jk_down_counter

Overview:
Presettable synchronous down counter. Every bit is a JK flip-flop wired in toggle mode (J=K=toggle term), matching the style of the team's existing up counter. It provides parallel load, count enable, hold-at-zero mode and a combinational borrow output. The borrow output allows instances to be cascaded into wider countdown timers and prescalers.

Parameters:
WIDTH, 4, number of counter bits (>=2).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset; clears state immediately, no clock needed
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value captured on load
en  input  1  count-down enable; cascade input from a lower stage's borrow
hold_at_zero  input  1  1 = stop at 0 instead of wrapping
count  output  WIDTH  current count (JK q outputs)
count_n  output  WIDTH  bitwise complement of count (JK qbar outputs)
zero  output  1  count == 0
borrow  output  1  underflow strobe for cascading

Behaviour:
- Reset (asynchronous, active-high): count=0, count_n=all ones, zero=1, borrow=0. The preset register (see Optional Feature) resets to all ones.
- Priority at each rising edge: reset > load > en. If none is active, all state holds.
- load=1: count <= load_val on the next edge, regardless of en or hold_at_zero.
- en=1, load=0: count <= count-1 mod 2^WIDTH.
- Toggle structure:
  - Bit 0 toggles when en is active.
  - Bit i toggles when en is active and bits 0..i-1 are all 0.
  - Each bit is implemented as JK with J=K=toggle_i.
  - No bit may use adder inference.
- hold_at_zero=1 and count==0: en is ignored and count stays 0.
- zero: combinational, (count==0).
- borrow: combinational, en & ~load & zero & ~hold_at_zero. It is high exactly in the cycle before the 0 -> wrap edge.
- count_n is always ~count, including during reset.
- Cascading: an upper stage's en is driven from the lower stage's borrow. The resulting WIDTH*N chain behaves as one synchronous down counter with no extra latency.
- Reset mid-operation: count returns to 0 asynchronously, and a pending load or en is discarded. The first edge after reset deasserts behaves normally.
- load_val is sampled only at a load edge. Changing load_val without load has no effect.

Optional Feature:
Macro AUTO_RELOAD_EN.
- Defined:
  - An internal WIDTH-bit preset register captures load_val on every load edge.
  - When borrow=1, the next edge loads count from the preset register instead of wrapping to all ones.
  - With no load since reset, the preset is all ones, so the first wrap is identical to plain wrap.
  - hold_at_zero=1 still suppresses the reload.
- Undefined: no preset register exists. Underflow wraps 0 -> 2^WIDTH-1.

Test Plan (WIDTH=4 unless stated):
1. Load 4'hA, then en=1 for 12 cycles -> count A,9,8,...,1,0,F,E. borrow is high only in the cycle where count=0. zero=1 only at count=0.
2. Count at 5 with en=1, assert reset between clock edges -> count=0, count_n=F, zero=1 with no clock edge. After reset deasserts, en=1 gives F on the next edge.
3. count=3, load=1 with load_val=7 and en=1 on the same edge -> count=7 (load wins), borrow=0 during that cycle.
4. hold_at_zero=1, load 2, en=1 -> 2,1,0,0,0. borrow stays 0. Then load 9 -> 9 regardless of hold.
5. Two instances cascaded (lower borrow -> upper en) as an 8-bit counter, load 8'h10, en=1 -> 8'h0F after 1 edge and 8'h00 after 16 edges. Next edge gives 8'hFF, with the upper stage's borrow high in the cycle before.
6. AUTO_RELOAD_EN defined: load 3, en=1 -> 3,2,1,0,3,2. Undefined: the same stimulus gives 3,2,1,0,F,E.

Source files
------------

// File: rtl/sync_jk_down_counter.sv
// ---------------------------------------------------------------------------
// sync_jk_down_counter
//
// Presettable synchronous down counter. Every bit is a JK flip-flop in
// toggle mode (J = K = toggle_i), built the same way as the existing up
// counter. The toggle terms come from an explicit ripple of "all lower bits
// are zero" terms, so no adder is inferred.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   load         in   synchronous parallel load strobe (beats en)
//   load_val     in   WIDTH  value captured on a load edge
//   en           in   count-down enable / cascade input from lower borrow
//   hold_at_zero in   1 = stop at zero instead of wrapping
//   count        out  WIDTH  current count (JK q)
//   count_n      out  WIDTH  complement of count (JK qbar)
//   zero         out  count == 0
//   borrow       out  underflow strobe, high in the cycle before 0 -> wrap
//
// Optional feature macro: AUTO_RELOAD_EN
//   Defined  : a preset register captures load_val on every load. On
//              underflow the counter reloads from it instead of wrapping.
//   Undefined: underflow wraps 0 -> 2^WIDTH-1.
// ---------------------------------------------------------------------------
module sync_jk_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             hold_at_zero,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             zero,
  output logic             borrow
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] jk_next;
  logic             en_eff;

  assign zero    = ~|count_q;
  assign count   = count_q;
  assign count_n = ~count_q;

  // Reset is included so that borrow stays low while reset is asserted,
  // even though count is zero and en may be high.
  assign borrow  = en & ~load & zero & ~hold_at_zero & ~reset;

  // Holding at zero simply removes the enable from the toggle chain.
  assign en_eff  = en & ~(hold_at_zero & zero);

  // A bit toggles when enabled and every lower bit is zero (down-count carry).
  always_comb begin
    toggle    = '0;
    toggle[0] = en_eff;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & ~count_q[i-1];
    end
  end

  // JK characteristic equation with J = K = toggle: q+ = J&~q | ~K&q.
  always_comb begin
    jk_next = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      jk_next[i] = (toggle[i] & ~count_q[i]) | (~toggle[i] & count_q[i]);
    end
  end

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] preset_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset_q <= '1;
    end else if (load) begin
      preset_q <= load_val;
    end
  end

  always_comb begin
    count_d = jk_next;
    if (load) begin
      count_d = load_val;
    end else if (borrow) begin
      count_d = preset_q;
    end
  end
`else
  always_comb begin
    count_d = jk_next;
    if (load) begin
      count_d = load_val;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sync_jk_down_counter.sv
module tb_sync_jk_down_counter;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       hold_at_zero;
  logic [3:0] count;
  logic [3:0] count_n;
  logic       zero;
  logic       borrow;

  // Cascaded pair forming an 8-bit counter.
  logic       c_load;
  logic [7:0] c_val;
  logic       c_en;
  logic [3:0] lo_count, lo_count_n, hi_count, hi_count_n;
  logic       lo_zero, lo_borrow, hi_zero, hi_borrow;
  logic [7:0] c_count;

  int errors;
  int checks;
  logic [3:0] exp4;
  logic [3:0] pre4;

  sync_jk_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
    .hold_at_zero(hold_at_zero), .count(count), .count_n(count_n),
    .zero(zero), .borrow(borrow)
  );

  sync_jk_down_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .reset(reset), .load(c_load), .load_val(c_val[3:0]), .en(c_en),
    .hold_at_zero(1'b0), .count(lo_count), .count_n(lo_count_n),
    .zero(lo_zero), .borrow(lo_borrow)
  );

  sync_jk_down_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .reset(reset), .load(c_load), .load_val(c_val[7:4]), .en(lo_borrow),
    .hold_at_zero(1'b0), .count(hi_count), .count_n(hi_count_n),
    .zero(hi_zero), .borrow(hi_borrow)
  );

  assign c_count = {hi_count, lo_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wrap target on underflow for the single 4-bit instance.
  function automatic logic [3:0] wrap_val(input logic [3:0] preset);
`ifdef AUTO_RELOAD_EN
    return preset;
`else
    return 4'hF;
`endif
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1; load = 1'b0; load_val = 4'h0; en = 1'b1; hold_at_zero = 1'b0;
    c_load = 1'b0; c_val = 8'h00; c_en = 1'b0;
    pre4 = 4'hF;
    #12;
    chk("rst_count",   {4'h0, count},   8'h00);
    chk("rst_count_n", {4'h0, count_n}, 8'h0F);
    chk("rst_zero",    {7'h0, zero},    8'h01);
    chk("rst_borrow",  {7'h0, borrow},  8'h00);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;

    // 1: load A then count 12 edges.
    load = 1'b1; load_val = 4'hA;
    tick();
    pre4 = 4'hA;
    load = 1'b0; en = 1'b1;
    load_val = 4'h3; // not loaded, must have no effect
    exp4 = 4'hA;
    for (int i = 0; i < 13; i++) begin
      chk("t1_count",  {4'h0, count},  {4'h0, exp4});
      chk("t1_cnt_n",  {4'h0, count_n}, {4'h0, ~exp4});
      chk("t1_zero",   {7'h0, zero},   {7'h0, exp4 == 4'h0});
      chk("t1_borrow", {7'h0, borrow}, {7'h0, exp4 == 4'h0});
      if (i < 12) begin
        tick();
        exp4 = (exp4 == 4'h0) ? wrap_val(pre4) : exp4 - 4'h1;
      end
    end

    // 2: asynchronous reset mid-count.
    en = 1'b0; load = 1'b1; load_val = 4'h6;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    chk("t2_pre", {4'h0, count}, 8'h05);
    #2 reset = 1'b1;
    #1;
    chk("t2_async_count",  {4'h0, count},   8'h00);
    chk("t2_async_cnt_n",  {4'h0, count_n}, 8'h0F);
    chk("t2_async_zero",   {7'h0, zero},    8'h01);
    @(negedge clk);
    reset = 1'b0;
    pre4 = 4'hF;
    tick();
    chk("t2_after_rst", {4'h0, count}, 8'h0F);

    // 3: load beats enable.
    en = 1'b0; load = 1'b1; load_val = 4'h3;
    tick();
    pre4 = 4'h3;
    chk("t3_pre", {4'h0, count}, 8'h03);
    load = 1'b1; load_val = 4'h7; en = 1'b1;
    #1;
    chk("t3_borrow", {7'h0, borrow}, 8'h00);
    tick();
    pre4 = 4'h7;
    chk("t3_count", {4'h0, count}, 8'h07);

    // 3b: load at zero with en suppresses borrow.
    load = 1'b1; load_val = 4'h0; en = 1'b0;
    tick();
    pre4 = 4'h0;
    load = 1'b1; load_val = 4'h4; en = 1'b1;
    #1;
    chk("t3b_borrow_load", {7'h0, borrow}, 8'h00);
    tick();
    pre4 = 4'h4;
    chk("t3b_count", {4'h0, count}, 8'h04);

    // 4: hold at zero.
    hold_at_zero = 1'b1; load = 1'b1; load_val = 4'h2; en = 1'b0;
    tick();
    pre4 = 4'h2;
    load = 1'b0; en = 1'b1;
    chk("t4_c2", {4'h0, count}, 8'h02);
    tick(); chk("t4_c1", {4'h0, count}, 8'h01);
    tick(); chk("t4_c0a", {4'h0, count}, 8'h00);
    chk("t4_borrow", {7'h0, borrow}, 8'h00);
    tick(); chk("t4_c0b", {4'h0, count}, 8'h00);
    tick(); chk("t4_c0c", {4'h0, count}, 8'h00);
    chk("t4_borrow2", {7'h0, borrow}, 8'h00);
    load = 1'b1; load_val = 4'h9;
    tick();
    pre4 = 4'h9;
    chk("t4_load9", {4'h0, count}, 8'h09);
    load = 1'b0; hold_at_zero = 1'b0; en = 1'b0;

    // 6: load 3 then count through underflow.
    load = 1'b1; load_val = 4'h3;
    tick();
    pre4 = 4'h3;
    load = 1'b0; en = 1'b1;
    chk("t6_c3", {4'h0, count}, 8'h03);
    tick(); chk("t6_c2", {4'h0, count}, 8'h02);
    tick(); chk("t6_c1", {4'h0, count}, 8'h01);
    tick(); chk("t6_c0", {4'h0, count}, 8'h00);
    tick();
`ifdef AUTO_RELOAD_EN
    chk("t6_wrap", {4'h0, count}, 8'h03);
    tick(); chk("t6_after", {4'h0, count}, 8'h02);
`else
    chk("t6_wrap", {4'h0, count}, 8'h0F);
    tick(); chk("t6_after", {4'h0, count}, 8'h0E);
`endif
    en = 1'b0;

    // 5: cascaded 8-bit counter.
    c_load = 1'b1; c_val = 8'h10;
    tick();
    c_load = 1'b0; c_en = 1'b1;
    chk("t5_loaded", c_count, 8'h10);
    tick();
`ifdef AUTO_RELOAD_EN
    // Lower stage reloads its preset of 0, upper decrements 1 -> 0.
    chk("t5_edge1", c_count, 8'h00);
    chk("t5_hi_borrow", {7'h0, hi_borrow}, 8'h01);
    tick();
    chk("t5_reload", c_count, 8'h10);
`else
    chk("t5_edge1", c_count, 8'h0F);
    for (int i = 0; i < 15; i++) begin
      chk("t5_hi_borrow_low", {7'h0, hi_borrow}, 8'h00);
      tick();
    end
    chk("t5_edge16", c_count, 8'h00);
    chk("t5_hi_borrow", {7'h0, hi_borrow}, 8'h01);
    chk("t5_cnt_n", {hi_count_n, lo_count_n}, 8'hFF);
    tick();
    chk("t5_wrap", c_count, 8'hFF);
    chk("t5_hi_borrow_off", {7'h0, hi_borrow}, 8'h00);
    tick();
    chk("t5_next", c_count, 8'hFE);
`endif
    c_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
